// File: rtl/tpu_io_pkg.sv
// tpu_io_pkg: shared constants for the TPU board I/O path.
//   N_BTN / N_SW             - conditioned button / switch channel counts
//                              (SW15 is reserved for reset and not conditioned)
//   DEBOUNCE_CYCLES_DEFAULT  - 10 ms stability window at 100 MHz
//   BASYS3_*                 - raw pin counts used by the board top wrapper
//   cnt_width()              - stability counter width for a given window
package tpu_io_pkg;

  localparam int N_BTN                   = 5;
  localparam int N_SW                    = 15;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;

  localparam int BASYS3_N_BTN = 5;
  localparam int BASYS3_N_SW  = 16;
  localparam int BASYS3_N_LED = 16;
  localparam int BASYS3_N_SEG = 7;
  localparam int BASYS3_N_AN  = 4;

  // A one-cycle window still needs a 1-bit counter to stay a legal vector.
  function automatic int cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/basys3_input_conditioner_if.sv
// basys3_input_conditioner_if: raw board pins in, conditioned levels/events out.
//   btn_raw, sw_raw        - asynchronous pins (driven by master)
//   btn_level, sw_level    - debounced levels
//   btn_press, btn_release - one-cycle per-bit button events
//   sw_changed             - one-cycle pulse on any switch change
// master = board/consumer side, slave = the conditioner.
interface basys3_input_conditioner_if #(
  parameter int N_BTN = tpu_io_pkg::N_BTN,
  parameter int N_SW  = tpu_io_pkg::N_SW
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_SW-1:0]  sw_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_SW-1:0]  sw_level;
  logic             sw_changed;

  modport master (
    output btn_raw, sw_raw,
    input  btn_level, btn_press, btn_release, sw_level, sw_changed
  );

  modport slave (
    input  btn_raw, sw_raw,
    output btn_level, btn_press, btn_release, sw_level, sw_changed
  );

endinterface

// File: rtl/debounce_bit.sv
// debounce_bit: one input channel - synchronizer, stability-counter debounce
// and edge detection.
//   clk, rst - system clock, synchronous active-high reset
//   raw      - asynchronous input pin
//   level    - debounced level
//   rise     - one-cycle pulse when a 0->1 change is accepted
//   fall     - one-cycle pulse when a 1->0 change is accepted
module debounce_bit
  import tpu_io_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   stable;
  logic [CNT_W-1:0]       cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Any sample agreeing with the accepted level restarts the window, so
  // only an uninterrupted run of DEBOUNCE_CYCLES differing samples wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (synced == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= synced;
        cnt    <= '0;
        rise   <= synced;
        fall   <= ~synced;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/basys3_input_conditioner.sv
// basys3_input_conditioner: conditions Basys3 buttons and switches for the
// TPU core. Each bit runs through its own debounce_bit channel.
//   clk, rst - system clock, synchronous active-high reset
//   io       - slave side of basys3_input_conditioner_if:
//              btn_raw/sw_raw in; btn_level, btn_press, btn_release,
//              sw_level, sw_changed out
module basys3_input_conditioner
  import tpu_io_pkg::*;
#(
  parameter int N_BTN           = tpu_io_pkg::N_BTN,
  parameter int N_SW            = tpu_io_pkg::N_SW,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input logic                       clk,
  input logic                       rst,
  basys3_input_conditioner_if.slave io
);

  logic [N_BTN-1:0] btn_stable;
  logic [N_BTN-1:0] btn_rise;
  logic [N_BTN-1:0] btn_fall;
  logic [N_SW-1:0]  sw_stable;
  logic [N_SW-1:0]  sw_rise;
  logic [N_SW-1:0]  sw_fall;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .raw   (io.btn_raw[i]),
      .level (btn_stable[i]),
      .rise  (btn_rise[i]),
      .fall  (btn_fall[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .rst   (rst),
      .raw   (io.sw_raw[i]),
      .level (sw_stable[i]),
      .rise  (sw_rise[i]),
      .fall  (sw_fall[i])
    );
  end

  assign io.btn_level   = btn_stable;
  assign io.btn_press   = btn_rise;
  assign io.btn_release = btn_fall;
  assign io.sw_level    = sw_stable;

  // The per-channel pulses are already flopped, so this OR lines sw_changed
  // up with the cycle in which sw_level changes.
  assign io.sw_changed = |(sw_rise | sw_fall);

endmodule

// File: doc/basys3_input_conditioner.md
# basys3_input_conditioner

Conditions the raw Basys3 push-button and slide-switch pins before they reach the TPU core. It sits between the board pins and the core's `sw`/`btn` inputs inside the top wrapper. Every input bit is synchronized into `clk`, debounced with a per-bit stability counter, and edge-detected. The core and the UART/debug logic receive clean levels plus single-cycle press, release and change events.

## Interface
Parameters:
- `N_BTN`, 5: number of push buttons.
- `N_SW`, 15: number of switches; SW15 is excluded because it drives reset.
- `SYNC_STAGES`, 2: synchronizer flop depth, minimum 2.
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required to accept a change, minimum 1. The default is 10 ms at 100 MHz.

Ports:
- `clk`  in  1: system clock. The block uses this one clock only.
- `rst`  in  1: synchronous, active-high reset.
- `btn_raw`  in  N_BTN: asynchronous button pins.
- `sw_raw`  in  N_SW: asynchronous switch pins.
- `btn_level`  out  N_BTN: debounced button state.
- `btn_press`  out  N_BTN: one-cycle pulse per bit on a debounced 0→1 transition.
- `btn_release`  out  N_BTN: one-cycle pulse per bit on a debounced 1→0 transition.
- `sw_level`  out  N_SW: debounced switch state.
- `sw_changed`  out  1: one-cycle pulse when any debounced switch bit changes.

## Operation
Each of the N_BTN+N_SW bits is an independent channel with the following stages.
- **Synchronizer:** SYNC_STAGES flops; the last stage is `synced`.
- **Debounce:** the channel holds a `stable` register and a counter `cnt`, width $clog2(DEBOUNCE_CYCLES). On each edge:
  - If `synced == stable`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `stable <= synced` and `cnt <= 0`.
  - Else: `cnt <= cnt+1`.
- **Glitch rejection:** any return of `synced` to `stable` before acceptance clears `cnt`. Glitches shorter than DEBOUNCE_CYCLES synchronized cycles never reach the outputs.
- **Rise/fall pulses:** registered on the same edge that updates `stable`. `rise` is set if the accepted value is 1; `fall` is set if it is 0. Otherwise both are 0.
- **Button outputs:** `btn_level = stable`, `btn_press = rise`, `btn_release = fall`.
- **`sw_changed`:** registered OR of all switch rise|fall terms. Any number of switches changing on the same edge produces one single-cycle pulse.
- **Channel independence:** button channels do not interact; simultaneous events appear as multi-bit pulse vectors in the same cycle.
- **Reset:** clears all synchronizer flops, `stable`, `cnt` and pulse registers. Reset mid-count discards the partial count.
- **Inputs high through reset:** they are treated as real 0→1 changes after release. They produce level, press and `sw_changed` after the full latency.

## Timing
- **Reset values:** all outputs are 0 while `rst` is high and on the first cycle after it is released.
- **Latency:** a raw step held steady is first sampled on edge 1. `stable`, the level output and the pulse all update on edge SYNC_STAGES+DEBOUNCE_CYCLES, and are visible in the following cycle. With the defaults this is edge 1_000_002.
- **Pulse width:** exactly one `clk` cycle.
- **Repeat events:** the minimum spacing between two accepted changes on one channel is DEBOUNCE_CYCLES cycles.
- **Handshake:** there is no backpressure; consumers must sample pulses every cycle.

## Structure
- **Shared package `tpu_io_pkg`:** holds `N_BTN`, `N_SW` and `DEBOUNCE_CYCLES_DEFAULT`. The same package gains the Basys3 pin-count constants used by the top wrapper.
- **Sub-module `debounce_bit`:** parameterized by SYNC_STAGES and DEBOUNCE_CYCLES. Ports: `clk`, `rst`, `raw` in, and `level`, `rise`, `fall` out.
- **Top:** instantiates `debounce_bit` N_BTN+N_SW times with `generate` and ORs the switch rise|fall terms into `sw_changed`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=8 and SYNC_STAGES=2, so the latency is 10 edges.
1. **Reset with inputs high:** `rst`=1 for 5 cycles with `btn_raw`=5'h1F and `sw_raw`=15'h7FFF → all outputs 0 during reset. After release: levels all 1 at edge 10, `btn_press`=5'h1F for one cycle, one `sw_changed` pulse.
2. **Clean press/release:** `btn_raw[2]` steps 0→1 → `btn_level`=5'b00100 ten edges later and `btn_press`=5'b00100 for exactly one cycle. A later 1→0 step → `btn_release`=5'b00100 for one cycle after 10 edges.
3. **Bounce:** `btn_raw[0]` toggles three times with 7-cycle high and 2-cycle low intervals, then holds high → no output activity during bouncing. `btn_level[0]` rises 10 edges after the final rising step, with one `btn_press` pulse.
4. **Glitch:** `sw_raw[3]` is high for 7 cycles, then low → `sw_level` stays 0 and `sw_changed` never asserts.
5. **Simultaneous switches:** `sw_raw[0]` and `sw_raw[14]` step high on the same edge → `sw_level`=15'h4001 in one cycle and `sw_changed` is high for exactly one cycle.
6. **Reset mid-count:** `rst` is pulsed for 1 cycle when `cnt`=5 on `btn_raw[1]`, with the input still held high → outputs stay 0. `btn_level[1]` rises 10 edges after reset release, not earlier.
